// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-bus (ibus) handshake bundle between the fetch
//                stage (master) and the instruction memory side (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        ireq_valid;     // request valid
    logic [31:0] ireq_addr;      // request address
    logic        iresp_addr_ok;  // request accepted this cycle
    logic        iresp_data_ok;  // instruction data returned this cycle
    logic [31:0] iresp_data;     // instruction word

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_addr_ok, iresp_data_ok, iresp_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : MIPS instruction-fetch stage. Owns the PC and the ibus
//                handshake and feeds the F->D register. Handles decode stall,
//                delayed branch redirect and CP0 flush.
//                Optional macro FETCH_PERF_CNT_EN adds perf_fetched and
//                perf_wait counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.master ibus,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic         flush_valid,
    input  logic [31:0]  flush_pc,
    output logic         d_valid,
    output logic [31:0]  d_pc,
    output logic [31:0]  d_instr,
    output logic         d_adel
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_wait
`endif
);

    localparam logic [2:0] c_ST_REQ   = 3'd0;  // issue request for fetch_pc
    localparam logic [2:0] c_ST_WAIT  = 3'd1;  // accepted, waiting for data
    localparam logic [2:0] c_ST_HOLD  = 3'd2;  // ready instruction parked by stall
    localparam logic [2:0] c_ST_DRAIN = 3'd3;  // discard one outstanding response
    localparam logic [2:0] c_ST_DROP  = 3'd4;  // finish an abandoned, unaccepted request

    logic [2:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        buf_adel_q, buf_adel_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_adel_q, d_adel_d;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        ready;
    logic [31:0] rdy_instr;
    logic        rdy_adel;
    logic        misaligned;
    logic        deliver;
    logic        park;
    logic        redir_take;

    assign misaligned = (fetch_pc_q[1:0] != 2'b00);
    assign deliver    = ready & ~stall & ~flush_valid;
    assign park       = ready &  stall & ~flush_valid;
    assign redir_take = redirect_valid & ~stall & ~flush_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= c_ST_REQ;
        else       state_q <= state_d;
    end

    // Next-state logic; flush overrides everything except bookkeeping of an
    // already-outstanding bus transaction
    always_comb begin
        state_d = state_q;
        if (flush_valid) begin
            case (state_q)
                c_ST_REQ: begin
                    if (req_valid && ibus.iresp_addr_ok && !ibus.iresp_data_ok) state_d = c_ST_DRAIN;
                    else if (req_valid && !ibus.iresp_addr_ok)                  state_d = c_ST_DROP;
                    else                                                        state_d = c_ST_REQ;
                end
                // A response arriving in the flush cycle itself leaves nothing to drain
                c_ST_WAIT:  state_d = ibus.iresp_data_ok ? c_ST_REQ : c_ST_DRAIN;
                c_ST_DRAIN: state_d = ibus.iresp_data_ok ? c_ST_REQ : c_ST_DRAIN;
                c_ST_DROP: begin
                    if (ibus.iresp_addr_ok) state_d = ibus.iresp_data_ok ? c_ST_REQ : c_ST_DRAIN;
                end
                default:    state_d = c_ST_REQ;
            endcase
        end else begin
            case (state_q)
                c_ST_REQ: begin
                    if (deliver)                             state_d = c_ST_REQ;
                    else if (park)                           state_d = c_ST_HOLD;
                    else if (req_valid && ibus.iresp_addr_ok) state_d = c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (deliver)   state_d = c_ST_REQ;
                    else if (park) state_d = c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    if (deliver) state_d = c_ST_REQ;
                end
                c_ST_DRAIN: begin
                    if (ibus.iresp_data_ok) state_d = c_ST_REQ;
                end
                c_ST_DROP: begin
                    if (ibus.iresp_addr_ok) state_d = ibus.iresp_data_ok ? c_ST_REQ : c_ST_DRAIN;
                end
                default: state_d = c_ST_REQ;
            endcase
        end
    end

    // State-decoded outputs: bus request and the "instruction ready" source
    always_comb begin
        req_valid = 1'b0;
        req_addr  = fetch_pc_q;
        ready     = 1'b0;
        rdy_instr = 32'h0;
        rdy_adel  = 1'b0;
        case (state_q)
            c_ST_REQ: begin
                if (misaligned) begin
                    ready    = 1'b1;
                    rdy_adel = 1'b1;
                end else begin
                    req_valid = 1'b1;
                    if (ibus.iresp_addr_ok && ibus.iresp_data_ok) begin
                        ready     = 1'b1;
                        rdy_instr = ibus.iresp_data;
                    end
                end
            end
            c_ST_WAIT: begin
                if (ibus.iresp_data_ok) begin
                    ready     = 1'b1;
                    rdy_instr = ibus.iresp_data;
                end
            end
            c_ST_HOLD: begin
                ready     = 1'b1;
                rdy_instr = buf_instr_q;
                rdy_adel  = buf_adel_q;
            end
            c_ST_DROP: begin
                req_valid = 1'b1;
                req_addr  = drop_addr_q;
            end
            default: ;
        endcase
    end

    assign ibus.ireq_valid = req_valid & ~reset;
    assign ibus.ireq_addr  = req_addr;

    // PC, buffer, pending redirect and D register next values
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        drop_addr_d  = drop_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_adel_d   = buf_adel_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        d_valid_d    = d_valid_q;
        d_pc_d       = d_pc_q;
        d_instr_d    = d_instr_q;
        d_adel_d     = d_adel_q;
        if (flush_valid) begin
            fetch_pc_d   = flush_pc;
            pend_valid_d = 1'b0;
            buf_instr_d  = 32'h0;
            buf_adel_d   = 1'b0;
            // Remember the address so the unaccepted request stays stable
            if (state_q == c_ST_REQ && req_valid && !ibus.iresp_addr_ok)
                drop_addr_d = fetch_pc_q;
            d_valid_d = 1'b0;
            d_pc_d    = 32'h0;
            d_instr_d = 32'h0;
            d_adel_d  = 1'b0;
        end else begin
            if (park) begin
                buf_instr_d = rdy_instr;
                buf_adel_d  = rdy_adel;
            end
            if (deliver) begin
                d_valid_d    = 1'b1;
                d_pc_d       = fetch_pc_q;
                d_instr_d    = rdy_instr;
                d_adel_d     = rdy_adel;
                pend_valid_d = 1'b0;
                if (redir_take)        fetch_pc_d = redirect_pc;
                else if (pend_valid_q) fetch_pc_d = pend_pc_q;
                else                   fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                // Delay slot not yet delivered: keep the target for later
                if (redir_take) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_pc;
                end
                if (!stall) begin
                    d_valid_d = 1'b0;
                    d_pc_d    = 32'h0;
                    d_instr_d = 32'h0;
                    d_adel_d  = 1'b0;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            drop_addr_q  <= 32'h0;
            buf_instr_q  <= 32'h0;
            buf_adel_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
            d_valid_q    <= 1'b0;
            d_pc_q       <= 32'h0;
            d_instr_q    <= 32'h0;
            d_adel_q     <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            drop_addr_q  <= drop_addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_adel_q   <= buf_adel_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            d_valid_q    <= d_valid_d;
            d_pc_q       <= d_pc_d;
            d_instr_q    <= d_instr_d;
            d_adel_q     <= d_adel_d;
        end
    end

    assign d_valid = d_valid_q;
    assign d_pc    = d_pc_q;
    assign d_instr = d_instr_q;
    assign d_adel  = d_adel_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_wait_q;

    // Delivery and bus-wait event counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= 32'h0;
            perf_wait_q    <= 32'h0;
        end else begin
            if (deliver) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (state_q != c_ST_HOLD && !ibus.iresp_data_ok) perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_wait    = perf_wait_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: directed scenarios plus
//                a randomized run against a program-order reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    localparam logic [31:0] KEY = 32'h0000_1234;
    localparam logic [31:0] RST = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, redirect_valid, flush_valid;
    logic [31:0] redirect_pc, flush_pc;
    logic        d_valid, d_adel;
    logic [31:0] d_pc, d_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_wait;
`endif
    int total = 0;
    int bad   = 0;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RST)) dut (
        .clk(clk), .reset(reset), .ibus(bus),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_adel(d_adel)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_wait(perf_wait)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic aok, input logic dok, input logic [31:0] data);
        bus.iresp_addr_ok = aok;
        bus.iresp_data_ok = dok;
        bus.iresp_data    = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0);
        stall = 1'b0; redirect_valid = 1'b0; flush_valid = 1'b0;
        redirect_pc = 32'h0; flush_pc = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        tick(); tick();
        total++;
        if (d_valid !== 1'b0 || d_pc !== 32'h0 || d_instr !== 32'h0 || d_adel !== 1'b0) begin
            bad++; $display("FAIL reset_d: got v=%b pc=%h i=%h adel=%b want all zero", d_valid, d_pc, d_instr, d_adel);
        end
        total++;
        if (bus.ireq_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ireq: got %b want 0", bus.ireq_valid);
        end
        reset = 1'b0; #1;
        total++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== RST) begin
            bad++; $display("FAIL reset_pc: got v=%b addr=%h want 1 %h", bus.ireq_valid, bus.ireq_addr, RST);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, bus.ireq_addr ^ KEY);
            tick();
            e = RST + 32'(4 * i);
            total++;
            if (d_valid !== 1'b1 || d_pc !== e || d_instr !== (e ^ KEY) || d_adel !== 1'b0) begin
                bad++; $display("FAIL b2b_%0d: got v=%b pc=%h i=%h want 1 %h %h", i, d_valid, d_pc, d_instr, e, e ^ KEY);
            end
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_stall_hold();
        logic [31:0] a;
        a = RST + 32'h10;
        total++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== a) begin
            bad++; $display("FAIL hold_req: got v=%b addr=%h want 1 %h", bus.ireq_valid, bus.ireq_addr, a);
        end
        drive(1'b1, 1'b0, 32'h0); tick();
        drive(1'b0, 1'b0, 32'h0); tick(); tick();
        stall = 1'b1; drive(1'b0, 1'b1, a ^ KEY); tick();
        drive(1'b0, 1'b0, 32'h0);
        total++;
        if (bus.ireq_valid !== 1'b0 || d_valid !== 1'b0) begin
            bad++; $display("FAIL hold_park: got ireq=%b dv=%b want 0 0", bus.ireq_valid, d_valid);
        end
        tick();
        stall = 1'b0;
        total++;
        if (bus.ireq_valid !== 1'b0 || d_valid !== 1'b0) begin
            bad++; $display("FAIL hold_still: got ireq=%b dv=%b want 0 0", bus.ireq_valid, d_valid);
        end
        tick();
        total++;
        if (d_valid !== 1'b1 || d_pc !== a || d_instr !== (a ^ KEY)) begin
            bad++; $display("FAIL hold_release: got v=%b pc=%h i=%h want 1 %h %h", d_valid, d_pc, d_instr, a, a ^ KEY);
        end
        total++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== a + 32'd4) begin
            bad++; $display("FAIL hold_next: got v=%b addr=%h want 1 %h", bus.ireq_valid, bus.ireq_addr, a + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        flush_valid = 1'b1; flush_pc = 32'h100; drive(1'b1, 1'b1, 32'hDEAD_BEEF); tick();
        flush_valid = 1'b0;
        drive(1'b1, 1'b1, 32'h100 ^ KEY); tick();
        total++;
        if (d_valid !== 1'b1 || d_pc !== 32'h100 || d_instr !== (32'h100 ^ KEY)) begin
            bad++; $display("FAIL br_load: got v=%b pc=%h i=%h want 1 00000100 %h", d_valid, d_pc, d_instr, 32'h100 ^ KEY);
        end
        drive(1'b1, 1'b0, 32'h0); redirect_valid = 1'b1; redirect_pc = 32'h200; tick();
        redirect_valid = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        total++;
        if (d_valid !== 1'b0 || bus.ireq_valid !== 1'b0) begin
            bad++; $display("FAIL br_bubble: got dv=%b ireq=%b want 0 0", d_valid, bus.ireq_valid);
        end
        drive(1'b0, 1'b1, 32'h104 ^ KEY); tick();
        drive(1'b0, 1'b0, 32'h0);
        total++;
        if (d_valid !== 1'b1 || d_pc !== 32'h104 || d_instr !== (32'h104 ^ KEY)) begin
            bad++; $display("FAIL br_slot: got v=%b pc=%h i=%h want 1 00000104 %h", d_valid, d_pc, d_instr, 32'h104 ^ KEY);
        end
        total++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h200) begin
            bad++; $display("FAIL br_target: got v=%b addr=%h want 1 00000200", bus.ireq_valid, bus.ireq_addr);
        end
    endtask

    task automatic test_flush_wait();
        drive(1'b1, 1'b0, 32'h0); tick();
        flush_valid = 1'b1; flush_pc = 32'hBFC0_0380; drive(1'b0, 1'b0, 32'h0); tick();
        flush_valid = 1'b0;
        drive(1'b0, 1'b1, 32'h200 ^ KEY); tick();
        drive(1'b0, 1'b0, 32'h0);
        total++;
        if (d_valid !== 1'b0 || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hBFC0_0380) begin
            bad++; $display("FAIL fl_drain: got dv=%b ireq=%b addr=%h want 0 1 bfc00380", d_valid, bus.ireq_valid, bus.ireq_addr);
        end
        drive(1'b1, 1'b1, 32'hBFC0_0380 ^ KEY); tick();
        drive(1'b0, 1'b0, 32'h0);
        total++;
        if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0380 || d_instr !== (32'hBFC0_0380 ^ KEY)) begin
            bad++; $display("FAIL fl_handler: got v=%b pc=%h i=%h want 1 bfc00380", d_valid, d_pc, d_instr);
        end
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b1, 32'hBFC0_0384 ^ KEY); redirect_valid = 1'b1; redirect_pc = 32'h202; tick();
        redirect_valid = 1'b0; drive(1'b0, 1'b0, 32'h0);
        total++;
        if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0384 || bus.ireq_valid !== 1'b0) begin
            bad++; $display("FAIL mis_slot: got v=%b pc=%h ireq=%b want 1 bfc00384 0", d_valid, d_pc, bus.ireq_valid);
        end
        tick();
        total++;
        if (d_valid !== 1'b1 || d_pc !== 32'h202 || d_instr !== 32'h0 || d_adel !== 1'b1 || bus.ireq_valid !== 1'b0) begin
            bad++; $display("FAIL mis_202: got v=%b pc=%h i=%h adel=%b ireq=%b want 1 202 0 1 0", d_valid, d_pc, d_instr, d_adel, bus.ireq_valid);
        end
        tick();
        total++;
        if (d_valid !== 1'b1 || d_pc !== 32'h206 || d_instr !== 32'h0 || d_adel !== 1'b1) begin
            bad++; $display("FAIL mis_206: got v=%b pc=%h i=%h adel=%b want 1 206 0 1", d_valid, d_pc, d_instr, d_adel);
        end
        flush_valid = 1'b1; flush_pc = 32'h300; tick();
        flush_valid = 1'b0;
        total++;
        if (d_valid !== 1'b0 || d_adel !== 1'b0 || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h300) begin
            bad++; $display("FAIL mis_flush: got dv=%b adel=%b ireq=%b addr=%h want 0 0 1 300", d_valid, d_adel, bus.ireq_valid, bus.ireq_addr);
        end
    endtask

    task automatic test_flush_drop();
        flush_valid = 1'b1; flush_pc = 32'h400; drive(1'b0, 1'b0, 32'h0); tick();
        flush_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h300 || d_valid !== 1'b0) begin
                bad++; $display("FAIL drop_hold_%0d: got ireq=%b addr=%h dv=%b want 1 300 0", i, bus.ireq_valid, bus.ireq_addr, d_valid);
            end
            if (i == 0) tick();
        end
        drive(1'b1, 1'b0, 32'h0); tick();
        total++;
        if (bus.ireq_valid !== 1'b0) begin
            bad++; $display("FAIL drop_drain: got ireq=%b want 0", bus.ireq_valid);
        end
        drive(1'b0, 1'b1, 32'h300 ^ KEY); tick();
        total++;
        if (d_valid !== 1'b0 || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h400) begin
            bad++; $display("FAIL drop_next: got dv=%b ireq=%b addr=%h want 0 1 400", d_valid, bus.ireq_valid, bus.ireq_addr);
        end
        drive(1'b1, 1'b1, 32'h400 ^ KEY); tick();
        drive(1'b0, 1'b0, 32'h0);
        total++;
        if (d_valid !== 1'b1 || d_pc !== 32'h400 || d_instr !== (32'h400 ^ KEY)) begin
            bad++; $display("FAIL drop_deliver: got v=%b pc=%h i=%h want 1 400 %h", d_valid, d_pc, d_instr, 32'h400 ^ KEY);
        end
    endtask

    // Model: instructions are delivered in program order; a redirect makes
    // the first delivery at or after it the delay slot, then the target.
    task automatic test_random();
        logic [31:0] exp_pc, tgt, out_addr, last_addr, ei, data;
        logic [31:0] p_rpc, p_fpc, pv_pc, pv_instr;
        logic        armed, outst, p_stall, p_flush, p_redir, pv_valid, pv_adel, last_pend, ea, aok, dok;
        int          cnt, lat, deliveries;
        reset = 1'b1; idle(); tick(); reset = 1'b0;
        exp_pc = RST; tgt = 32'h0; armed = 1'b0; outst = 1'b0; out_addr = 32'h0; cnt = 0;
        p_stall = 1'b0; p_flush = 1'b0; p_redir = 1'b0; p_rpc = 32'h0; p_fpc = 32'h0;
        pv_valid = 1'b0; pv_pc = 32'h0; pv_instr = 32'h0; pv_adel = 1'b0;
        last_pend = 1'b0; last_addr = 32'h0; deliveries = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                if (p_flush) begin
                    total++;
                    if (d_valid !== 1'b0 || d_pc !== 32'h0 || d_instr !== 32'h0 || d_adel !== 1'b0) begin
                        bad++; $display("FAIL rnd_flush cyc=%0d: got v=%b pc=%h want bubble", cyc, d_valid, d_pc);
                    end
                    exp_pc = p_fpc; armed = 1'b0;
                end else begin
                    if (p_redir) begin armed = 1'b1; tgt = p_rpc; end
                    if (p_stall) begin
                        total++;
                        if (d_valid !== pv_valid || d_pc !== pv_pc || d_instr !== pv_instr || d_adel !== pv_adel) begin
                            bad++; $display("FAIL rnd_stall cyc=%0d: got v=%b pc=%h want v=%b pc=%h", cyc, d_valid, d_pc, pv_valid, pv_pc);
                        end
                    end else if (d_valid === 1'b1) begin
                        ea = (exp_pc[1:0] != 2'b00);
                        ei = ea ? 32'h0 : (exp_pc ^ KEY);
                        total++;
                        if (d_pc !== exp_pc || d_instr !== ei || d_adel !== ea) begin
                            bad++; $display("FAIL rnd_deliver cyc=%0d: got pc=%h i=%h adel=%b want %h %h %b", cyc, d_pc, d_instr, d_adel, exp_pc, ei, ea);
                        end
                        deliveries++;
                        exp_pc = armed ? tgt : exp_pc + 32'd4;
                        armed  = 1'b0;
                    end else begin
                        total++;
                        if (d_pc !== 32'h0 || d_instr !== 32'h0 || d_adel !== 1'b0) begin
                            bad++; $display("FAIL rnd_bubble cyc=%0d: got pc=%h i=%h adel=%b want zero", cyc, d_pc, d_instr, d_adel);
                        end
                    end
                end
                if (last_pend) begin
                    total++;
                    if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== last_addr) begin
                        bad++; $display("FAIL rnd_bus_hold cyc=%0d: got v=%b addr=%h want 1 %h", cyc, bus.ireq_valid, bus.ireq_addr, last_addr);
                    end
                end
                if (outst) begin
                    total++;
                    if (bus.ireq_valid !== 1'b0) begin
                        bad++; $display("FAIL rnd_extra_req cyc=%0d: got ireq=1 want 0", cyc);
                    end
                end
            end
            // Memory side: in-order, one outstanding, latency 0..3 after accept
            aok = 1'b0; dok = 1'b0; data = 32'h0;
            if (outst) begin
                if (cnt == 0) begin dok = 1'b1; data = out_addr ^ KEY; outst = 1'b0; end
                else cnt--;
            end else if (bus.ireq_valid === 1'b1 && $urandom_range(0, 9) < 7) begin
                aok = 1'b1;
                lat = int'($urandom_range(0, 3));
                if (lat == 0) begin dok = 1'b1; data = bus.ireq_addr ^ KEY; end
                else begin outst = 1'b1; out_addr = bus.ireq_addr; cnt = lat - 1; end
            end
            last_pend = (bus.ireq_valid === 1'b1) && !aok;
            last_addr = bus.ireq_addr;
            // Decode/CP0 side
            stall          = ($urandom_range(0, 3) == 0);
            flush_valid    = ($urandom_range(0, 39) == 0);
            flush_pc       = $urandom & 32'h0000_0FFC;
            redirect_valid = !stall && !armed && ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0);
            drive(aok, dok, data);
            p_stall = stall; p_flush = flush_valid; p_redir = redirect_valid;
            p_rpc = redirect_pc; p_fpc = flush_pc;
            pv_valid = d_valid; pv_pc = d_pc; pv_instr = d_instr; pv_adel = d_adel;
            tick();
        end
        idle();
        total++;
        if (deliveries < 300) begin
            bad++; $display("FAIL rnd_progress: got %0d deliveries want >= 300", deliveries);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_hold();
        test_redirect_wait();
        test_flush_wait();
        test_misaligned();
        test_flush_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC and the instruction-bus (ibus) handshake, and feeds the F→D pipeline register consumed by the decode stage (pc, instruction word, fetch exception).
- Honours the decode stall (load-use), the decode branch/jump redirect with MIPS delay-slot semantics, and the CP0 exception/eret flush.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ireq_valid  out  1  ibus request valid
- ireq_addr  out  32  ibus request address
- iresp_addr_ok  in  1  request accepted this cycle
- iresp_data_ok  in  1  instruction data returned this cycle
- iresp_data  in  32  instruction word
- stall  in  1  decode stall (load-use); freezes D register
- redirect_valid  in  1  decode branch/jump taken
- redirect_pc  in  32  branch/jump target
- flush_valid  in  1  exception/eret flush from CP0 logic
- flush_pc  in  32  handler/EPC address
- d_valid  out  1  D register holds a real instruction
- d_pc  out  32  D register PC
- d_instr  out  32  D register instruction (0 = NOP when bubble or faulted)
- d_adel  out  1  fetch address error (AdEL) for d_pc

Behaviour:
- Reset (edge with reset=1): fetch_pc=RESET_PC, state=REQ, buffer empty, pending redirect cleared. d_valid=0, d_pc=0, d_instr=0, d_adel=0, ireq_valid=0 during reset. Reset mid-transaction abandons it; the ibus must also be reset.
- States:
  - REQ: if fetch_pc[1:0]!=0, no bus request; the instruction becomes ready with instr=0 and adel=1. Otherwise ireq_valid=1, ireq_addr=fetch_pc. addr_ok&data_ok → ready; addr_ok only → WAIT.
  - WAIT: ireq_valid=0; data_ok → ready.
  - HOLD: ready instruction parked in the 1-entry buffer because stall=1.
  - DRAIN: one outstanding response to discard; on data_ok → REQ.
  - DROP: unaccepted request kept with the same addr until addr_ok, then DRAIN. If data_ok arrives with addr_ok, go straight to REQ.
- Bus rule: while ireq_valid=1 and addr_ok=0, ireq_addr is stable and ireq_valid is not withdrawn.
- Delivery:
  - A ready instruction (from the bus or the buffer) loads D at the first edge with stall=0, setting d_valid=1.
  - With stall=1 it goes to the buffer (HOLD).
  - Delivery advances fetch_pc and returns to REQ.
  - Back-to-back addr_ok&data_ok with no stall gives 1 instruction/cycle; data_ok→d_valid latency is 1 edge.
- D update:
  - stall=1: D holds.
  - stall=0 and nothing ready: D becomes a bubble (d_valid=0, d_instr=0, d_adel=0, d_pc=0).
- Next PC on delivery, priority order:
  1. redirect_valid&!stall this edge → redirect_pc.
  2. Pending redirect → pending_pc.
  3. fetch_pc+4.
- Redirect:
  - Sampled only when stall=0.
  - The instruction currently being fetched is the delay slot and is always delivered.
  - A redirect accepted without a same-edge delivery is stored as pending and cleared on the next delivery.
  - A new redirect while one is pending is not possible: the delay slot must be delivered first.
- Flush (highest priority, any state, ignores stall):
  - D becomes a bubble; buffer and pending redirect cleared; fetch_pc=flush_pc.
  - WAIT → DRAIN. REQ with addr_ok&!data_ok this cycle → DRAIN. REQ with ireq_valid&!addr_ok → DROP. Otherwise → REQ.
  - A flush during DRAIN/DROP keeps the state and only updates fetch_pc.
- Simultaneous flush and redirect: the redirect is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32 bit, increments on each delivery to D) and perf_wait (32 bit, increments on each cycle in REQ/WAIT/DRAIN/DROP without data_ok). Both reset to 0 and wrap at 2^32.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Reset, then ibus returns addr_ok&data_ok every cycle with data=pc^32'h1234 → d_pc=BFC00000, BFC00004, BFC00008 on consecutive cycles; d_valid=1 from the second cycle.
- data_ok 3 cycles after addr_ok, stall=1 for 2 cycles over the return → instruction held in HOLD; d_valid=1 with the correct word one edge after stall drops; no second request for pc+4 until delivery.
- Branch at 0x100 in D with redirect_pc=0x200 while the delay-slot fetch (0x104) is still in WAIT → D bubble, then 0x104 delivered, next ireq_addr=0x200.
- flush_valid with flush_pc=0xBFC00380 while in WAIT → the next data_ok is discarded (D stays bubble), the next request goes to 0xBFC00380, d_pc=BFC00380.
- redirect_pc=0x202 → after the delay slot, no ireq_valid; d_pc=0x202, d_instr=0, d_adel=1; next fetch 0x206 is also faulted until a flush to a valid address.
- flush in REQ while addr_ok=0 for 2 cycles → ireq_addr unchanged until addr_ok, response discarded, then request at flush_pc.
